// File: rtl/decode_pkg.sv
// Shared decode definitions for the issue/decode stage: RV32I opcodes,
// ALU / immediate selector enums, per-lane control struct and the issue FSM
// state type.
package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [0:0] {
    ISSUE_ALL = 1'b0,
    SPLIT     = 1'b1
  } issue_state_e;

  // Fields registered per output slot.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       alu_src;
    imm_src_e   imm_src;
    alu_ctrl_e  alu_ctrl;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } slot_t;

  // Full decoder output: slot fields plus memory-port and hazard information.
  typedef struct packed {
    slot_t      slot;
    logic       mem_op;
    logic       mem_write;
    logic [1:0] mem_mode;
    logic       mem_unsigned;
    logic       uses_rs1;
    logic       uses_rs2;
  } lane_ctrl_t;

  // funct3 -> ALU op; alt selects sub/sra (instr[30]).
  function automatic alu_ctrl_e alu_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/lane_decoder.sv
// Combinational RV32I decoder for one lane.
//   instr : 32-bit instruction
//   ctrl  : decoded control fields, register indices and operand-use flags
module lane_decoder
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output lane_ctrl_t  ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin : dec
    logic bad;
    bad            = 1'b0;
    ctrl           = '0;
    ctrl.slot.rd   = instr[11:7];
    ctrl.slot.rs1  = instr[19:15];
    ctrl.slot.rs2  = instr[24:20];
    ctrl.slot.imm_src  = IMM_I;
    ctrl.slot.alu_ctrl = ALU_ADD;
    case (opcode)
      OP_REG: begin
        ctrl.slot.reg_write = 1'b1;
        ctrl.uses_rs1       = 1'b1;
        ctrl.uses_rs2       = 1'b1;
        ctrl.slot.alu_ctrl  = alu_op(funct3, funct7[5]);
        bad = !(funct7 == F7_BASE ||
                (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OP_IMM: begin
        ctrl.slot.reg_write = 1'b1;
        ctrl.slot.alu_src   = 1'b1;
        ctrl.uses_rs1       = 1'b1;
        // instr[30] is immediate data except for shifts.
        ctrl.slot.alu_ctrl  = alu_op(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001) bad = (funct7 != F7_BASE);
        else if (funct3 == 3'b101) bad = (funct7 != F7_BASE) && (funct7 != F7_ALT);
      end
      OP_LOAD: begin
        ctrl.slot.reg_write  = 1'b1;
        ctrl.slot.result_src = RES_MEM;
        ctrl.slot.alu_src    = 1'b1;
        ctrl.uses_rs1        = 1'b1;
        ctrl.mem_op          = 1'b1;
        ctrl.mem_mode        = funct3[1:0];
        ctrl.mem_unsigned    = funct3[2];
        bad = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
      end
      OP_STORE: begin
        ctrl.slot.alu_src = 1'b1;
        ctrl.slot.imm_src = IMM_S;
        ctrl.uses_rs1     = 1'b1;
        ctrl.uses_rs2     = 1'b1;
        ctrl.mem_op       = 1'b1;
        ctrl.mem_write    = 1'b1;
        ctrl.mem_mode     = funct3[1:0];
        bad = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OP_BRANCH: begin
        ctrl.slot.branch  = 1'b1;
        ctrl.slot.imm_src = IMM_B;
        ctrl.uses_rs1     = 1'b1;
        ctrl.uses_rs2     = 1'b1;
        // beq/bne compare by subtraction, the rest by signed/unsigned slt.
        if (!funct3[2]) ctrl.slot.alu_ctrl = ALU_SUB;
        else if (!funct3[1]) ctrl.slot.alu_ctrl = ALU_SLT;
        else ctrl.slot.alu_ctrl = ALU_SLTU;
        bad = (funct3[2:1] == 2'b01);
      end
      OP_JAL: begin
        ctrl.slot.reg_write  = 1'b1;
        ctrl.slot.jump       = 1'b1;
        ctrl.slot.result_src = RES_PC4;
        ctrl.slot.imm_src    = IMM_J;
      end
      OP_JALR: begin
        ctrl.slot.reg_write  = 1'b1;
        ctrl.slot.jump       = 1'b1;
        ctrl.slot.result_src = RES_PC4;
        ctrl.slot.alu_src    = 1'b1;
        ctrl.uses_rs1        = 1'b1;
        bad = (funct3 != 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        ctrl.slot.reg_write = 1'b1;
        ctrl.slot.alu_src   = 1'b1;
        ctrl.slot.imm_src   = IMM_U;
      end
      default: bad = 1'b1;
    endcase
    // An illegal slot still issues but must have no architectural side effect
    // and must not take part in hazard detection.
    if (bad) begin
      ctrl.slot.illegal   = 1'b1;
      ctrl.slot.reg_write = 1'b0;
      ctrl.slot.branch    = 1'b0;
      ctrl.slot.jump      = 1'b0;
      ctrl.mem_write      = 1'b0;
      ctrl.mem_op         = 1'b0;
      ctrl.uses_rs1       = 1'b0;
      ctrl.uses_rs2       = 1'b0;
    end
  end

endmodule

// File: rtl/issue_decode_stage.sv
// N-lane in-order decode/issue stage. Decodes a fetch group, splits it over
// several cycles on intra-group RAW hazards or memory-port conflicts, steers
// memory ops into MEM_LANE and registers the result into the D stage.
//   clk, reset (async, active high), flush (squash pending + registered group)
//   in_valid/in_ready/instr    : fetch-group input
//   out_valid/out_ready        : per-slot registered output handshake
//   reg_write..rs2, mem_*      : registered control fields
//   dbg_state                  : current issue FSM state
//
// Handshake: a group transfers on a cycle where in_valid && in_ready; while a
// group is being split in_ready stays 0 and the fetch buffer holds the same
// group. The output register loads when it is empty or out_ready is high, and
// otherwise holds every output unchanged.
module issue_decode_stage
  import decode_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int MEM_LANE  = NUM_LANES - 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_LANES-1:0][31:0]  instr,
  output logic [NUM_LANES-1:0]        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LANES-1:0]        reg_write,
  output logic [NUM_LANES-1:0][1:0]   result_src,
  output logic                        mem_write,
  output logic [1:0]                  mem_mode,
  output logic                        mem_unsigned,
  output logic [NUM_LANES-1:0]        alu_src,
  output logic [NUM_LANES-1:0][2:0]   imm_src,
  output logic [NUM_LANES-1:0][3:0]   alu_ctrl,
  output logic [NUM_LANES-1:0]        branch,
  output logic [NUM_LANES-1:0]        jump,
  output logic [NUM_LANES-1:0]        illegal,
  output logic [NUM_LANES-1:0][4:0]   rd,
  output logic [NUM_LANES-1:0][4:0]   rs1,
  output logic [NUM_LANES-1:0][4:0]   rs2,
  output issue_state_e                dbg_state
);

  lane_ctrl_t [NUM_LANES-1:0] ctrl;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_dec
    lane_decoder u_dec (
      .instr (instr[g]),
      .ctrl  (ctrl[g])
    );
  end

  issue_state_e               state_q, state_d;
  logic [NUM_LANES-1:0]       pending_q, pending_d;
  logic [NUM_LANES-1:0]       valid_q, valid_d;
  slot_t [NUM_LANES-1:0]      slot_q, slot_d;
  logic                       mem_write_q, mem_write_d;
  logic [1:0]                 mem_mode_q, mem_mode_d;
  logic                       mem_unsigned_q, mem_unsigned_d;

  logic [NUM_LANES-1:0]       avail, issue, remaining, new_valid;
  slot_t [NUM_LANES-1:0]      new_slot;
  logic                       new_mem_write, new_mem_unsigned;
  logic [1:0]                 new_mem_mode;
  logic                       steer, load_en, group_done;

  // Pick the oldest run of available lanes that can issue together.
  always_comb begin : issue_select
    logic seen, stop, conflict;
    avail = (state_q == SPLIT) ? pending_q : {NUM_LANES{in_valid}};
    issue = '0;
    steer = 1'b0;
    seen  = 1'b0;
    stop  = 1'b0;
    for (int j = 0; j < NUM_LANES; j++) begin
      conflict = 1'b0;
      if (avail[j] && !stop) begin
        if (!seen) begin
          seen     = 1'b1;
          issue[j] = 1'b1;
          // A memory op outside MEM_LANE goes alone, steered to MEM_LANE.
          if (ctrl[j].mem_op && j != MEM_LANE) begin
            steer = 1'b1;
            stop  = 1'b1;
          end
        end else begin
          if (ctrl[j].mem_op && j != MEM_LANE) conflict = 1'b1;
          for (int i = 0; i < NUM_LANES; i++) begin
            if (i < j && issue[i]) begin
              if (ctrl[i].mem_op && ctrl[j].mem_op) conflict = 1'b1;
              if (ctrl[i].slot.reg_write && ctrl[i].slot.rd != 5'd0 &&
                  ((ctrl[j].uses_rs1 && ctrl[j].slot.rs1 == ctrl[i].slot.rd) ||
                   (ctrl[j].uses_rs2 && ctrl[j].slot.rs2 == ctrl[i].slot.rd)))
                conflict = 1'b1;
            end
          end
          if (conflict) stop = 1'b1;
          else issue[j] = 1'b1;
        end
      end
    end
  end

  assign remaining  = avail & ~issue;
  assign group_done = (remaining == '0);
  assign load_en    = !(|valid_q) || out_ready;
  assign in_ready   = flush || (load_en && group_done);

  // Build the slot contents for the lanes selected this cycle.
  always_comb begin : slot_build
    new_slot         = '0;
    new_valid        = '0;
    new_mem_write    = 1'b0;
    new_mem_mode     = 2'b00;
    new_mem_unsigned = 1'b0;
    for (int s = 0; s < NUM_LANES; s++) begin
      if (!steer && issue[s]) begin
        new_slot[s]  = ctrl[s].slot;
        new_valid[s] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_LANES; j++) begin
      if (issue[j] && (steer || j == MEM_LANE)) begin
        new_mem_write    = ctrl[j].mem_write;
        new_mem_mode     = ctrl[j].mem_mode;
        new_mem_unsigned = ctrl[j].mem_unsigned;
      end
      if (issue[j] && steer) begin
        new_slot[MEM_LANE]  = ctrl[j].slot;
        new_valid[MEM_LANE] = 1'b1;
      end
    end
  end

  always_comb begin : next_state
    state_d        = state_q;
    pending_d      = pending_q;
    valid_d        = valid_q;
    slot_d         = slot_q;
    mem_write_d    = mem_write_q;
    mem_mode_d     = mem_mode_q;
    mem_unsigned_d = mem_unsigned_q;
    if (flush) begin
      state_d        = ISSUE_ALL;
      pending_d      = '0;
      valid_d        = '0;
      slot_d         = '0;
      mem_write_d    = 1'b0;
      mem_mode_d     = 2'b00;
      mem_unsigned_d = 1'b0;
    end else if (load_en) begin
      valid_d        = new_valid;
      slot_d         = new_slot;
      mem_write_d    = new_mem_write;
      mem_mode_d     = new_mem_mode;
      mem_unsigned_d = new_mem_unsigned;
      if (group_done) begin
        state_d   = ISSUE_ALL;
        pending_d = '0;
      end else begin
        state_d   = SPLIT;
        pending_d = remaining;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ISSUE_ALL;
      pending_q      <= '0;
      valid_q        <= '0;
      slot_q         <= '0;
      mem_write_q    <= 1'b0;
      mem_mode_q     <= 2'b00;
      mem_unsigned_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      valid_q        <= valid_d;
      slot_q         <= slot_d;
      mem_write_q    <= mem_write_d;
      mem_mode_q     <= mem_mode_d;
      mem_unsigned_q <= mem_unsigned_d;
    end
  end

  assign out_valid    = valid_q;
  assign mem_write    = mem_write_q;
  assign mem_mode     = mem_mode_q;
  assign mem_unsigned = mem_unsigned_q;
  assign dbg_state    = state_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_out
    assign reg_write[g]  = slot_q[g].reg_write;
    assign result_src[g] = slot_q[g].result_src;
    assign alu_src[g]    = slot_q[g].alu_src;
    assign imm_src[g]    = slot_q[g].imm_src;
    assign alu_ctrl[g]   = slot_q[g].alu_ctrl;
    assign branch[g]     = slot_q[g].branch;
    assign jump[g]       = slot_q[g].jump;
    assign illegal[g]    = slot_q[g].illegal;
    assign rd[g]         = slot_q[g].rd;
    assign rs1[g]        = slot_q[g].rs1;
    assign rs2[g]        = slot_q[g].rs2;
  end

endmodule
